led_payload_writer: RTL and testbench
=====================================

LED_PAYLOAD_WRITER -- requirements
Module: led_payload_writer

Interface
REQ-001 SHALL have parameter FB_ADDR_WIDTH, default 11, giving the framebuffer pixel address width (2048 pixels).
REQ-002 SHALL have parameter LED_ETH_TYPE, default 16'h88B5, the accepted EtherType.
REQ-003 SHALL have parameter LOCAL_MAC, default 48'h020000000001, the accepted unicast destination.
REQ-004 SHALL have one clock; reset is asynchronous and active-low: clk in 1, rising-edge clock.
REQ-005 rst_n in 1: asynchronous active-low reset.
REQ-006 s_eth_hdr_valid in 1: header valid.
REQ-007 s_eth_hdr_ready out 1: header accept.
REQ-008 s_eth_dest_mac in 48: destination MAC.
REQ-009 s_eth_type in 16: EtherType.
REQ-010 s_eth_payload_axis_tdata in 8: payload byte.
REQ-011 s_eth_payload_axis_tvalid in 1, s_eth_payload_axis_tready out 1, s_eth_payload_axis_tlast in 1, s_eth_payload_axis_tuser in 1 (bad frame at tlast).
REQ-012 fb_wr_en out 1, fb_wr_addr out FB_ADDR_WIDTH, fb_wr_data out 24 ({R,G,B}): framebuffer write port.
REQ-013 frame_done out 1: one-cycle pulse per good frame; frame_count out 16, drop_count out 16: saturating counters; busy out 1: state not IDLE.

Function
REQ-014 SHALL implement states IDLE, OFS_HI, OFS_LO, PIX_R, PIX_G, PIX_B, DROP.
REQ-015 IDLE: s_eth_hdr_ready=1, payload tready=0; all other states: s_eth_hdr_ready=0, payload tready=1 (never stalls payload).
REQ-016 Header handshake in IDLE: dest_mac equal to LOCAL_MAC or all-ones AND eth_type equal to LED_ETH_TYPE -> OFS_HI; otherwise -> DROP.
REQ-017 Byte accepted = tvalid AND tready; OFS_HI/OFS_LO capture big-endian 16-bit start offset; pixel address = offset[FB_ADDR_WIDTH-1:0] (upper bits ignored).
REQ-018 PIX_R, PIX_G, PIX_B capture colour bytes in order; PIX_B acceptance returns to PIX_R.
REQ-019 fb_wr_en SHALL pulse exactly one cycle after the PIX_B byte is accepted, with current address and {R,G,B}; address then increments modulo 2^FB_ADDR_WIDTH (wraps 2047->0).
REQ-020 tlast accepted in PIX_B with tuser=0 -> frame_done pulse (same cycle as final fb_wr_en), frame_count+1, -> IDLE.
REQ-021 tlast in OFS_HI, OFS_LO, PIX_R, PIX_G (runt or partial pixel) -> partial pixel discarded, no write, drop_count+1, -> IDLE.
REQ-022 tlast with tuser=1 in any pixel state -> final pixel still written if complete, no frame_done, drop_count+1 instead of frame_count; earlier writes are not undone.
REQ-023 DROP consumes bytes without writing until tlast, then drop_count+1, -> IDLE.
REQ-024 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-025 Payload bytes presented in IDLE are not accepted and have no effect.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, fb_wr_en=0, frame_done=0, fb_wr_addr=0, fb_wr_data=0, frame_count=0, drop_count=0, busy=0, s_eth_hdr_ready=0 while asserted.
REQ-027 Reset mid-frame SHALL abandon the frame with no further writes; after release, remaining bytes of that frame are not accepted until the next header.

Structure
REQ-028 Package matrixled_pkg SHALL hold the state enumeration, LED_ETH_TYPE default, pixel width (24) and counter width (16).
REQ-029 Sub-module sat_counter16 (increment enable, saturating) SHALL be instantiated for frame_count and drop_count; no other sub-modules.

Verification
REQ-030 Header type 88B5 to LOCAL_MAC, payload 00 05 FF 00 00 10 20 30 tlast -> writes addr5=FF0000, addr6=102030, frame_done once, frame_count=1.
REQ-031 Header type 0800 with 10 payload bytes -> no fb_wr_en, drop_count=1, tready held 1 until tlast.
REQ-032 Offset 07 FF, two pixels -> writes at 2047 then 0 (wrap).
REQ-033 Payload 00 00 AA BB tlast -> no write, drop_count=1, state IDLE.
REQ-034 Valid one-pixel frame with tuser=1 at tlast -> one write, frame_done=0, drop_count=1; repeated so drop_count preloaded 0xFFFF stays 0xFFFF.
REQ-035 rst_n low after PIX_G -> no write, all outputs zero; next valid frame writes normally.

Source files
------------

// File: rtl/matrixled_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrixled_pkg
//  Description : Shared definitions for the LED matrix payload path:
//                FSM state encoding, default EtherType, pixel and counter
//                widths.
//  Contents    : PIXEL_WIDTH, COUNT_WIDTH, LED_ETH_TYPE_DEFAULT,
//                state_t and the ST_* state constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package matrixled_pkg;

  // One framebuffer word is {R,G,B}, one byte each.
  localparam int unsigned PIXEL_WIDTH = 24;

  // Width of the frame / drop statistics counters.
  localparam int unsigned COUNT_WIDTH = 16;

  // EtherType carried by LED payload frames.
  localparam logic [15:0] LED_ETH_TYPE_DEFAULT = 16'h88B5;

  // Receive FSM state enumeration.
  localparam int unsigned STATE_WIDTH = 3;
  typedef logic [STATE_WIDTH-1:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_OFS_HI = 3'd1;
  localparam state_t ST_OFS_LO = 3'd2;
  localparam state_t ST_PIX_R  = 3'd3;
  localparam state_t ST_PIX_G  = 3'd4;
  localparam state_t ST_PIX_B  = 3'd5;
  localparam state_t ST_DROP   = 3'd6;

endpackage : matrixled_pkg
`default_nettype wire

// File: rtl/sat_counter16.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter16
//  Description : 16-bit up counter with increment enable that sticks at
//                all-ones instead of wrapping.
//  Ports       : clk     - rising-edge clock
//                rst_n   - asynchronous active-low reset (clears count)
//                inc_i   - add one on this clock edge (ignored at maximum)
//                count_o - current count
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter16
  import matrixled_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inc_i,
  output logic [COUNT_WIDTH-1:0] count_o
);

  localparam logic [COUNT_WIDTH-1:0] C_MAX = {COUNT_WIDTH{1'b1}};

  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != C_MAX)) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : sat_counter16
`default_nettype wire

// File: rtl/led_payload_writer.sv
`default_nettype none
// ============================================================================
//  Module      : led_payload_writer
//  Description : Receives LED payload Ethernet frames (header + byte stream)
//                and writes RGB pixels into a framebuffer. Payload layout:
//                16-bit big-endian start offset followed by R,G,B triples.
//                Frames with a foreign destination or EtherType are
//                consumed and counted as drops.
//  Ports       : clk, rst_n                       - clock, async active-low reset
//                s_eth_hdr_valid/ready            - header handshake
//                s_eth_dest_mac, s_eth_type       - header fields
//                s_eth_payload_axis_t*            - payload byte stream
//                fb_wr_en/addr/data               - framebuffer write port
//                frame_done                       - pulse per good frame
//                frame_count, drop_count          - saturating statistics
//                busy                             - FSM is inside a frame
//  Revision    : 1.0 - initial release
// ============================================================================
module led_payload_writer
  import matrixled_pkg::*;
#(
  parameter int unsigned FB_ADDR_WIDTH = 11,
  parameter logic [15:0] LED_ETH_TYPE  = LED_ETH_TYPE_DEFAULT,
  parameter logic [47:0] LOCAL_MAC     = 48'h02_00_00_00_00_01
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     s_eth_hdr_valid,
  output logic                     s_eth_hdr_ready,
  input  logic [47:0]              s_eth_dest_mac,
  input  logic [15:0]              s_eth_type,

  input  logic [7:0]               s_eth_payload_axis_tdata,
  input  logic                     s_eth_payload_axis_tvalid,
  output logic                     s_eth_payload_axis_tready,
  input  logic                     s_eth_payload_axis_tlast,
  input  logic                     s_eth_payload_axis_tuser,

  output logic                     fb_wr_en,
  output logic [FB_ADDR_WIDTH-1:0] fb_wr_addr,
  output logic [PIXEL_WIDTH-1:0]   fb_wr_data,

  output logic                     frame_done,
  output logic [COUNT_WIDTH-1:0]   frame_count,
  output logic [COUNT_WIDTH-1:0]   drop_count,
  output logic                     busy
);

  localparam logic [47:0] C_BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t                   state_q,    state_d;
  logic [7:0]               ofs_hi_q,   ofs_hi_d;
  logic [FB_ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [7:0]               red_q,      red_d;
  logic [7:0]               grn_q,      grn_d;
  logic                     wr_en_q,    wr_en_d;
  logic [FB_ADDR_WIDTH-1:0] wr_addr_q,  wr_addr_d;
  logic [PIXEL_WIDTH-1:0]   wr_data_q,  wr_data_d;
  logic                     done_q,     done_d;

  logic                     frame_inc;
  logic                     drop_inc;
  logic                     beat;
  logic                     hdr_match;
  logic [15:0]              offset_w;
  logic [FB_ADDR_WIDTH-1:0] addr_load;

  // --------------------------------------------------------------------------
  // Handshakes. While rst_n is low state_q is already IDLE, but the header
  // side must not advertise ready during reset, hence the rst_n gate.
  // --------------------------------------------------------------------------
  assign s_eth_hdr_ready           = rst_n && (state_q == ST_IDLE);
  assign s_eth_payload_axis_tready = (state_q != ST_IDLE);
  assign busy                      = (state_q != ST_IDLE);

  assign beat = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;

  assign hdr_match = ((s_eth_dest_mac == LOCAL_MAC) || (s_eth_dest_mac == C_BCAST_MAC))
                     && (s_eth_type == LED_ETH_TYPE);

  // --------------------------------------------------------------------------
  // Start offset -> pixel address. The offset is always 16 bits on the wire;
  // bits above the framebuffer address width are ignored, and a framebuffer
  // wider than 16 bits is zero-extended.
  // --------------------------------------------------------------------------
  assign offset_w = {ofs_hi_q, s_eth_payload_axis_tdata};

  if (FB_ADDR_WIDTH < 16) begin : g_ofs_trunc
    logic [15-FB_ADDR_WIDTH:0] unused_ofs_bits;
    assign addr_load       = offset_w[FB_ADDR_WIDTH-1:0];
    assign unused_ofs_bits = offset_w[15:FB_ADDR_WIDTH];
  end else if (FB_ADDR_WIDTH == 16) begin : g_ofs_exact
    assign addr_load = offset_w;
  end else begin : g_ofs_extend
    assign addr_load = {{(FB_ADDR_WIDTH-16){1'b0}}, offset_w};
  end

  // --------------------------------------------------------------------------
  // Receive FSM. Payload is never stalled outside IDLE, so every state only
  // reacts to accepted bytes; tlast always returns to IDLE.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    ofs_hi_d  = ofs_hi_q;
    addr_d    = addr_q;
    red_d     = red_q;
    grn_d     = grn_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    frame_inc = 1'b0;
    drop_inc  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_eth_hdr_valid) begin
          state_d = hdr_match ? ST_OFS_HI : ST_DROP;
        end
      end

      ST_OFS_HI: begin
        if (beat) begin
          ofs_hi_d = s_eth_payload_axis_tdata;
          if (s_eth_payload_axis_tlast) begin
            drop_inc = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d  = ST_OFS_LO;
          end
        end
      end

      ST_OFS_LO: begin
        if (beat) begin
          addr_d = addr_load;
          if (s_eth_payload_axis_tlast) begin
            drop_inc = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d  = ST_PIX_R;
          end
        end
      end

      ST_PIX_R: begin
        if (beat) begin
          red_d = s_eth_payload_axis_tdata;
          if (s_eth_payload_axis_tlast) begin
            drop_inc = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d  = ST_PIX_G;
          end
        end
      end

      ST_PIX_G: begin
        if (beat) begin
          grn_d = s_eth_payload_axis_tdata;
          if (s_eth_payload_axis_tlast) begin
            drop_inc = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d  = ST_PIX_B;
          end
        end
      end

      ST_PIX_B: begin
        if (beat) begin
          // The pixel is complete, so it is written even on a bad frame.
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = {red_q, grn_q, s_eth_payload_axis_tdata};
          addr_d    = addr_q + FB_ADDR_WIDTH'(1);
          if (s_eth_payload_axis_tlast) begin
            state_d = ST_IDLE;
            if (s_eth_payload_axis_tuser) begin
              drop_inc  = 1'b1;
            end else begin
              frame_inc = 1'b1;
              done_d    = 1'b1;
            end
          end else begin
            state_d = ST_PIX_R;
          end
        end
      end

      ST_DROP: begin
        if (beat && s_eth_payload_axis_tlast) begin
          drop_inc = 1'b1;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ofs_hi_q  <= '0;
      addr_q    <= '0;
      red_q     <= '0;
      grn_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ofs_hi_q  <= ofs_hi_d;
      addr_q    <= addr_d;
      red_q     <= red_d;
      grn_q     <= grn_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign fb_wr_en   = wr_en_q;
  assign fb_wr_addr = wr_addr_q;
  assign fb_wr_data = wr_data_q;
  assign frame_done = done_q;

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
  sat_counter16 u_frame_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (frame_inc),
    .count_o (frame_count)
  );

  sat_counter16 u_drop_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (drop_inc),
    .count_o (drop_count)
  );

endmodule : led_payload_writer
`default_nettype wire

// File: tb/tb_led_payload_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_led_payload_writer
//  Description : Self-checking bench for led_payload_writer. Expected
//                framebuffer writes are queued as frames are sent and
//                checked by a monitor when fb_wr_en fires.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_payload_writer;

  localparam int FBW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             s_eth_hdr_valid;
  logic             s_eth_hdr_ready;
  logic [47:0]      s_eth_dest_mac;
  logic [15:0]      s_eth_type;
  logic [7:0]       tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;
  logic             tuser;
  logic             fb_wr_en;
  logic [FBW-1:0]   fb_wr_addr;
  logic [23:0]      fb_wr_data;
  logic             frame_done;
  logic [15:0]      frame_count;
  logic [15:0]      drop_count;
  logic             busy;

  logic             sat_inc;
  logic [15:0]      sat_count;

  led_payload_writer #(
    .FB_ADDR_WIDTH (FBW),
    .LED_ETH_TYPE  (16'h88B5),
    .LOCAL_MAC     (48'h020000000001)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .s_eth_hdr_valid           (s_eth_hdr_valid),
    .s_eth_hdr_ready           (s_eth_hdr_ready),
    .s_eth_dest_mac            (s_eth_dest_mac),
    .s_eth_type                (s_eth_type),
    .s_eth_payload_axis_tdata  (tdata),
    .s_eth_payload_axis_tvalid (tvalid),
    .s_eth_payload_axis_tready (tready),
    .s_eth_payload_axis_tlast  (tlast),
    .s_eth_payload_axis_tuser  (tuser),
    .fb_wr_en                  (fb_wr_en),
    .fb_wr_addr                (fb_wr_addr),
    .fb_wr_data                (fb_wr_data),
    .frame_done                (frame_done),
    .frame_count               (frame_count),
    .drop_count                (drop_count),
    .busy                      (busy)
  );

  // Stand-alone counter instance so saturation can be reached in a few
  // tens of thousands of cycles rather than by sending 65535 frames.
  sat_counter16 u_sat (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (sat_inc),
    .count_o (sat_count)
  );

  typedef struct packed {
    logic [FBW-1:0] addr;
    logic [23:0]    data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] pay_q[$];
  int         n_checks   = 0;
  int         n_fail     = 0;
  int         done_seen  = 0;
  int         exp_frames = 0;
  int         exp_drops  = 0;

  localparam logic [47:0] MAC_OK    = 48'h020000000001;
  localparam logic [47:0] MAC_OTHER = 48'h020000000002;
  localparam logic [47:0] MAC_BCAST = 48'hFFFFFFFFFFFF;

  // --------------------------------------------------------------------------
  // Write monitor / scoreboard
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && fb_wr_en) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d data=%06h, required no write",
                 fb_wr_addr, fb_wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({fb_wr_addr, fb_wr_data} !== {e.addr, e.data}) begin
          n_fail++;
          $display("FAIL write_value: got addr=%0d data=%06h, required addr=%0d data=%06h",
                   fb_wr_addr, fb_wr_data, e.addr, e.data);
        end
      end
    end
    if (rst_n && frame_done) begin
      done_seen++;
      n_checks++;
      if (fb_wr_en !== 1'b1) begin
        n_fail++;
        $display("FAIL done_with_write: fb_wr_en=%b at frame_done, required 1", fb_wr_en);
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (called at posedge+1)
  // --------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_header(input logic [47:0] mac, input logic [15:0] et);
    int t;
    t = 0;
    s_eth_hdr_valid = 1'b1;
    s_eth_dest_mac  = mac;
    s_eth_type      = et;
    @(negedge clk);
    while (!s_eth_hdr_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!s_eth_hdr_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL hdr_timeout: hdr_ready=%b after %0d cycles, required 1", s_eth_hdr_ready, t);
    end
    @(posedge clk);
    #1;
    s_eth_hdr_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic user);
    int t;
    t = 0;
    tvalid = 1'b1;
    tdata  = d;
    tlast  = last;
    tuser  = user;
    @(negedge clk);
    while (!tready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!tready) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_timeout: tready=%b after %0d cycles, required 1", tready, t);
    end
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    tuser  = 1'b0;
  endtask

  // Sends pay_q back-to-back, tlast on the final byte.
  task automatic send_payload(input logic user_at_last);
    int n;
    n = pay_q.size();
    for (int i = 0; i < n; i++) begin
      send_byte(pay_q[i], (i == n - 1), (i == n - 1) ? user_at_last : 1'b0);
    end
    pay_q.delete();
  endtask

  task automatic push_wr(input int a, input logic [23:0] d);
    wr_t e;
    e.addr = FBW'(a);
    e.data = d;
    exp_q.push_back(e);
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    idle(2);
    @(negedge clk);
    n_checks++;
    if ({fb_wr_en, frame_done, busy, s_eth_hdr_ready, tready} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got wr_en/done/busy/hdr_rdy/trdy=%b, required 00000",
               {fb_wr_en, frame_done, busy, s_eth_hdr_ready, tready});
    end
    n_checks++;
    if ({fb_wr_addr, fb_wr_data, frame_count, drop_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got addr=%0d data=%06h fc=%0d dc=%0d, required all 0",
               fb_wr_addr, fb_wr_data, frame_count, drop_count);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    n_checks++;
    if ({s_eth_hdr_ready, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL post_reset_idle: got hdr_ready=%b busy=%b, required 1 0", s_eth_hdr_ready, busy);
    end
  endtask

  task automatic check_end(input string name, input int done_before, input int done_delta);
    idle(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_writes: %0d expected writes missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if ({frame_count, drop_count} !== {16'(exp_frames), 16'(exp_drops)}) begin
      n_fail++;
      $display("FAIL %s_counters: got fc=%0d dc=%0d, required fc=%0d dc=%0d",
               name, frame_count, drop_count, exp_frames, exp_drops);
    end
    n_checks++;
    if ((done_seen - done_before) != done_delta || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: got %0d frame_done busy=%b, required %0d busy=0",
               name, done_seen - done_before, busy, done_delta);
    end
  endtask

  task automatic test_basic_frame();
    int d0;
    d0 = done_seen;
    send_header(MAC_OK, 16'h88B5);
    pay_q = '{8'h00, 8'h05, 8'hFF, 8'h00, 8'h00, 8'h10, 8'h20, 8'h30};
    push_wr(5, 24'hFF0000);
    push_wr(6, 24'h102030);
    send_payload(1'b0);
    exp_frames++;
    check_end("basic", d0, 1);
  endtask

  task automatic test_wrong_type();
    int d0;
    d0 = done_seen;
    send_header(MAC_OK, 16'h0800);
    for (int i = 0; i < 10; i++) begin
      send_byte(8'(i * 7 + 1), (i == 9), 1'b0);
      if (i < 9) begin
        n_checks++;
        if (tready !== 1'b1) begin
          n_fail++;
          $display("FAIL drop_tready: got tready=%b after byte %0d, required 1", tready, i);
        end
      end
    end
    exp_drops++;
    check_end("wrong_type", d0, 0);
    // Unicast to someone else is dropped too.
    send_header(MAC_OTHER, 16'h88B5);
    pay_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
    send_payload(1'b0);
    exp_drops++;
    check_end("wrong_mac", d0, 0);
  endtask

  task automatic test_broadcast_upper_ofs();
    int d0;
    d0 = done_seen;
    send_header(MAC_BCAST, 16'h88B5);
    // Offset 0x0803: bits above the 11-bit address are ignored -> 3.
    pay_q = '{8'h08, 8'h03, 8'h44, 8'h55, 8'h66};
    push_wr(3, 24'h445566);
    send_payload(1'b0);
    exp_frames++;
    check_end("bcast", d0, 1);
  endtask

  task automatic test_wrap();
    int d0;
    d0 = done_seen;
    send_header(MAC_OK, 16'h88B5);
    pay_q = '{8'h07, 8'hFF, 8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3};
    push_wr(2047, 24'hA1A2A3);
    push_wr(0,    24'hB1B2B3);
    send_payload(1'b0);
    exp_frames++;
    check_end("wrap", d0, 1);
  endtask

  task automatic test_runt();
    int d0;
    d0 = done_seen;
    send_header(MAC_OK, 16'h88B5);
    pay_q = '{8'h00, 8'h00, 8'hAA, 8'hBB};
    send_payload(1'b0);
    exp_drops++;
    check_end("runt", d0, 0);
    // Truncated inside the offset.
    send_header(MAC_OK, 16'h88B5);
    pay_q = '{8'h00};
    send_payload(1'b0);
    exp_drops++;
    check_end("runt_ofs", d0, 0);
  endtask

  task automatic test_bad_frame();
    int d0;
    d0 = done_seen;
    for (int k = 0; k < 2; k++) begin
      send_header(MAC_OK, 16'h88B5);
      pay_q = '{8'h00, 8'h40, 8'(8'hC0 + k), 8'hC5, 8'hC9};
      push_wr(64, {8'(8'hC0 + k), 8'hC5, 8'hC9});
      send_payload(1'b1);
      exp_drops++;
      check_end("bad_frame", d0, 0);
    end
  endtask

  task automatic test_idle_bytes();
    int d0;
    d0 = done_seen;
    tvalid = 1'b1;
    tdata  = 8'h00;
    tlast  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (tready !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_tready: got tready=%b in IDLE, required 0", tready);
      end
      tdata = 8'h05;
    end
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    send_header(MAC_OK, 16'h88B5);
    pay_q = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC};
    push_wr(1, 24'hAABBCC);
    send_payload(1'b0);
    exp_frames++;
    check_end("idle_bytes", d0, 1);
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_seen;
    send_header(MAC_OK, 16'h88B5);
    pay_q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03};
    push_wr(256, 24'h010203);
    send_payload(1'b0);
    send_header(MAC_OK, 16'h88B5);
    pay_q = '{8'h01, 8'h00, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    push_wr(256, 24'h040506);
    push_wr(257, 24'h070809);
    send_payload(1'b0);
    exp_frames += 2;
    check_end("b2b", d0, 2);
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    send_header(MAC_OK, 16'h88B5);
    pay_q = '{8'h00, 8'h00, 8'h11, 8'h22};
    for (int i = 0; i < 4; i++) send_byte(pay_q[i], 1'b0, 1'b0);
    pay_q.delete();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({fb_wr_en, frame_done, fb_wr_addr, fb_wr_data, frame_count, drop_count,
         busy, s_eth_hdr_ready, tready} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got wr_en=%b addr=%0d data=%06h fc=%0d dc=%0d busy=%b hrdy=%b, required all 0",
               fb_wr_en, fb_wr_addr, fb_wr_data, frame_count, drop_count, busy, s_eth_hdr_ready);
    end
    exp_frames = 0;
    exp_drops  = 0;
    idle(2);
    rst_n = 1'b1;
    // Remainder of the abandoned frame must be ignored.
    tvalid = 1'b1;
    tdata  = 8'h33;
    tlast  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (tready !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset_leftover: got tready=%b, required 0", tready);
      end
    end
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    d0 = done_seen;
    send_header(MAC_OK, 16'h88B5);
    pay_q = '{8'h00, 8'h10, 8'h01, 8'h02, 8'h03};
    push_wr(16, 24'h010203);
    send_payload(1'b0);
    exp_frames++;
    check_end("after_reset", d0, 1);
  endtask

  task automatic test_saturation();
    n_checks++;
    if (sat_count !== 16'd0) begin
      n_fail++;
      $display("FAIL sat_start: got %0d, required 0", sat_count);
    end
    sat_inc = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    n_checks++;
    if (sat_count !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL sat_fffe: got %04h, required FFFE", sat_count);
    end
    idle(1);
    n_checks++;
    if (sat_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_reach: got %04h, required FFFF", sat_count);
    end
    idle(5);
    n_checks++;
    if (sat_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_hold: got %04h, required FFFF", sat_count);
    end
    sat_inc = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    s_eth_hdr_valid = 1'b0;
    s_eth_dest_mac  = '0;
    s_eth_type      = '0;
    tdata           = '0;
    tvalid          = 1'b0;
    tlast           = 1'b0;
    tuser           = 1'b0;
    sat_inc         = 1'b0;
    #1;

    test_reset();
    test_basic_frame();
    test_wrong_type();
    test_broadcast_upper_ofs();
    test_wrap();
    test_runt();
    test_bad_frame();
    test_idle_bytes();
    test_back_to_back();
    test_reset_mid_frame();
    test_saturation();

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_led_payload_writer
`default_nettype wire
